// File: rtl/ahb2apb_master_arb.sv
// rtl/ahb2apb_master_arb.sv - two-master round-robin arbiter feeding one AHB-to-APB bridge slave port
module ahb2apb_master_arb #(
    parameter int ADDRWIDTH = 16,
    parameter int DATAWIDTH = 32
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    // master 0
    input  logic                 HSEL_M0,
    input  logic [ADDRWIDTH-1:0] HADDR_M0,
    input  logic                 HWRITE_M0,
    input  logic [1:0]           HTRANS_M0,
    input  logic [2:0]           HSIZE_M0,
    input  logic [3:0]           HPROT_M0,
    input  logic [DATAWIDTH-1:0] HWDATA_M0,
    input  logic                 HREADY_M0,
    output logic                 HREADYOUT_M0,
    output logic [DATAWIDTH-1:0] HRDATA_M0,
    output logic                 HRESP_M0,
    // master 1
    input  logic                 HSEL_M1,
    input  logic [ADDRWIDTH-1:0] HADDR_M1,
    input  logic                 HWRITE_M1,
    input  logic [1:0]           HTRANS_M1,
    input  logic [2:0]           HSIZE_M1,
    input  logic [3:0]           HPROT_M1,
    input  logic [DATAWIDTH-1:0] HWDATA_M1,
    input  logic                 HREADY_M1,
    output logic                 HREADYOUT_M1,
    output logic [DATAWIDTH-1:0] HRDATA_M1,
    output logic                 HRESP_M1,
    // bridge slave port
    output logic                 B_HSEL,
    output logic [ADDRWIDTH-1:0] B_HADDR,
    output logic                 B_HWRITE,
    output logic [1:0]           B_HTRANS,
    output logic [2:0]           B_HSIZE,
    output logic [3:0]           B_HPROT,
    output logic [DATAWIDTH-1:0] B_HWDATA,
    output logic                 B_HREADY,
    input  logic                 B_HREADYOUT,
    input  logic [DATAWIDTH-1:0] B_HRDATA,
    input  logic                 B_HRESP,
    output logic                 ARB_ACTIVE
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   gnt_q, gnt_d;
    logic   last_gnt_q, last_gnt_d;
    logic   xfer_done;

    // per-master inputs gathered into arrays so both slots share one description
    logic [1:0]           m_hsel;
    logic [1:0]           m_hwrite;
    logic [1:0]           m_hready;
    logic [1:0]           m_htrans_nonidle;
    logic [ADDRWIDTH-1:0] m_haddr  [2];
    logic [2:0]           m_hsize  [2];
    logic [3:0]           m_hprot  [2];
    logic [DATAWIDTH-1:0] m_hwdata [2];

    assign m_hsel           = {HSEL_M1, HSEL_M0};
    assign m_hwrite         = {HWRITE_M1, HWRITE_M0};
    assign m_hready         = {HREADY_M1, HREADY_M0};
    assign m_htrans_nonidle = {HTRANS_M1[1], HTRANS_M0[1]};
    assign m_haddr[0]       = HADDR_M0;
    assign m_haddr[1]       = HADDR_M1;
    assign m_hsize[0]       = HSIZE_M0;
    assign m_hsize[1]       = HSIZE_M1;
    assign m_hprot[0]       = HPROT_M0;
    assign m_hprot[1]       = HPROT_M1;
    assign m_hwdata[0]      = HWDATA_M0;
    assign m_hwdata[1]      = HWDATA_M1;

    // NONSEQ and SEQ are handled alike; only bit 1 of HTRANS distinguishes a real transfer
    logic unused_htrans_lsb;
    assign unused_htrans_lsb = HTRANS_M0[0] ^ HTRANS_M1[0];

    // slot state seen by the arbiter and output logic
    logic [1:0]           pend;
    logic [1:0]           elig;
    logic [1:0]           err1;
    logic [1:0]           err2;
    logic [1:0]           s_write;
    logic [ADDRWIDTH-1:0] s_addr  [2];
    logic [2:0]           s_size  [2];
    logic [3:0]           s_prot  [2];
    logic [DATAWIDTH-1:0] s_wdata [2];
    logic [DATAWIDTH-1:0] s_rdata [2];

    assign xfer_done = (state_q == ST_DATA) & B_HREADYOUT;

    for (genvar m = 0; m < 2; m++) begin : g_slot
        localparam logic SLOT_ID = (m == 1);

        logic                 pend_q;
        logic                 dph_q;
        logic                 wdok_q;
        logic                 err1_q;
        logic                 err2_q;
        logic                 write_q;
        logic [ADDRWIDTH-1:0] addr_q;
        logic [2:0]           size_q;
        logic [3:0]           prot_q;
        logic [DATAWIDTH-1:0] wdata_q;
        logic [DATAWIDTH-1:0] rdata_q;
        logic                 req;
        logic                 done;

        // a new request is only looked at while the slot is empty and not signalling an error
        assign req  = m_hsel[m] & m_htrans_nonidle[m] & m_hready[m] & ~pend_q & ~err1_q;
        assign done = xfer_done & (gnt_q == SLOT_ID);

        // slot capture: address phase, then write data one edge later, then completion
        always_ff @(posedge HCLK or negedge HRESETn) begin
            if (!HRESETn) begin
                pend_q  <= 1'b0;
                dph_q   <= 1'b0;
                wdok_q  <= 1'b0;
                write_q <= 1'b0;
                addr_q  <= '0;
                size_q  <= '0;
                prot_q  <= '0;
                wdata_q <= '0;
                rdata_q <= '0;
            end else begin
                if (req) begin
                    pend_q  <= 1'b1;
                    dph_q   <= 1'b1;
                    wdok_q  <= 1'b0;
                    write_q <= m_hwrite[m];
                    addr_q  <= m_haddr[m];
                    size_q  <= m_hsize[m];
                    prot_q  <= m_hprot[m];
                end else if (dph_q) begin
                    dph_q  <= 1'b0;
                    wdok_q <= 1'b1;
                    if (write_q) begin
                        wdata_q <= m_hwdata[m];
                    end
                end
                if (done) begin
                    pend_q  <= 1'b0;
                    wdok_q  <= 1'b0;
                    rdata_q <= B_HRDATA;
                end
            end
        end

        // two-cycle error response: first cycle stalls the master, second releases it
        always_ff @(posedge HCLK or negedge HRESETn) begin
            if (!HRESETn) begin
                err1_q <= 1'b0;
                err2_q <= 1'b0;
            end else begin
                err1_q <= done & B_HRESP;
                err2_q <= err1_q;
            end
        end

        assign pend[m]    = pend_q;
        assign elig[m]    = pend_q & wdok_q;
        assign err1[m]    = err1_q;
        assign err2[m]    = err2_q;
        assign s_write[m] = write_q;
        assign s_addr[m]  = addr_q;
        assign s_size[m]  = size_q;
        assign s_prot[m]  = prot_q;
        assign s_wdata[m] = wdata_q;
        assign s_rdata[m] = rdata_q;
    end

    // FSM state, current grant and round-robin history
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= ST_IDLE;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    // next-state, arbitration and bridge-side drive
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        B_HSEL     = 1'b0;
        B_HTRANS   = 2'b00;
        B_HREADY   = 1'b1;
        B_HADDR    = '0;
        B_HWRITE   = 1'b0;
        B_HSIZE    = '0;
        B_HPROT    = '0;
        B_HWDATA   = '0;
        case (state_q)
            ST_IDLE: begin
                if (|elig) begin
                    // with both eligible, the master not served last time wins
                    gnt_d      = (elig == 2'b11) ? ~last_gnt_q : elig[1];
                    last_gnt_d = gnt_d;
                    state_d    = ST_ADDR;
                end
            end
            ST_ADDR: begin
                B_HSEL   = 1'b1;
                B_HTRANS = 2'b10;
                B_HADDR  = s_addr[gnt_q];
                B_HWRITE = s_write[gnt_q];
                B_HSIZE  = s_size[gnt_q];
                B_HPROT  = s_prot[gnt_q];
                state_d  = ST_DATA;
            end
            ST_DATA: begin
                B_HWDATA = s_wdata[gnt_q];
                B_HREADY = B_HREADYOUT;
                if (B_HREADYOUT) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign HREADYOUT_M0 = ~pend[0] & ~err1[0];
    assign HRESP_M0     = err1[0] | err2[0];
    assign HRDATA_M0    = s_rdata[0];
    assign HREADYOUT_M1 = ~pend[1] & ~err1[1];
    assign HRESP_M1     = err1[1] | err2[1];
    assign HRDATA_M1    = s_rdata[1];
    assign ARB_ACTIVE   = (|pend) | (state_q != ST_IDLE);

endmodule

// File: tb/tb_ahb2apb_master_arb.sv
// tb/tb_ahb2apb_master_arb.sv - scoreboard bench for ahb2apb_master_arb
module tb_ahb2apb_master_arb;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL_M0, HWRITE_M0, HREADY_M0, HREADYOUT_M0, HRESP_M0;
    logic [15:0] HADDR_M0;
    logic [1:0]  HTRANS_M0;
    logic [2:0]  HSIZE_M0;
    logic [3:0]  HPROT_M0;
    logic [31:0] HWDATA_M0, HRDATA_M0;
    logic        HSEL_M1, HWRITE_M1, HREADY_M1, HREADYOUT_M1, HRESP_M1;
    logic [15:0] HADDR_M1;
    logic [1:0]  HTRANS_M1;
    logic [2:0]  HSIZE_M1;
    logic [3:0]  HPROT_M1;
    logic [31:0] HWDATA_M1, HRDATA_M1;
    logic        B_HSEL, B_HWRITE, B_HREADY, B_HREADYOUT, B_HRESP, ARB_ACTIVE;
    logic [15:0] B_HADDR;
    logic [1:0]  B_HTRANS;
    logic [2:0]  B_HSIZE;
    logic [3:0]  B_HPROT;
    logic [31:0] B_HWDATA, B_HRDATA;

    ahb2apb_master_arb #(.ADDRWIDTH(16), .DATAWIDTH(32)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .HSEL_M0(HSEL_M0), .HADDR_M0(HADDR_M0), .HWRITE_M0(HWRITE_M0), .HTRANS_M0(HTRANS_M0),
        .HSIZE_M0(HSIZE_M0), .HPROT_M0(HPROT_M0), .HWDATA_M0(HWDATA_M0), .HREADY_M0(HREADY_M0),
        .HREADYOUT_M0(HREADYOUT_M0), .HRDATA_M0(HRDATA_M0), .HRESP_M0(HRESP_M0),
        .HSEL_M1(HSEL_M1), .HADDR_M1(HADDR_M1), .HWRITE_M1(HWRITE_M1), .HTRANS_M1(HTRANS_M1),
        .HSIZE_M1(HSIZE_M1), .HPROT_M1(HPROT_M1), .HWDATA_M1(HWDATA_M1), .HREADY_M1(HREADY_M1),
        .HREADYOUT_M1(HREADYOUT_M1), .HRDATA_M1(HRDATA_M1), .HRESP_M1(HRESP_M1),
        .B_HSEL(B_HSEL), .B_HADDR(B_HADDR), .B_HWRITE(B_HWRITE), .B_HTRANS(B_HTRANS),
        .B_HSIZE(B_HSIZE), .B_HPROT(B_HPROT), .B_HWDATA(B_HWDATA), .B_HREADY(B_HREADY),
        .B_HREADYOUT(B_HREADYOUT), .B_HRDATA(B_HRDATA), .B_HRESP(B_HRESP),
        .ARB_ACTIVE(ARB_ACTIVE)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        int          m;
        logic [15:0] addr;
        logic        wr;
        logic [31:0] wdata;
        int          ws;
        logic [31:0] rdata;
        logic        resp;
    } bexp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } mexp_t;

    bexp_t bq[$];
    mexp_t mq0[$];
    mexp_t mq1[$];

    int checks = 0;
    int errors = 0;

    // {hsel, htrans[1:0], hready} patterns that must not start a transfer
    logic [3:0] ign_pat [4] = '{4'b0101, 4'b1011, 4'b1100, 4'b1001};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_b(input int m, input logic [15:0] a, input logic wr, input logic [31:0] wd,
                          input int ws, input logic [31:0] rd, input logic resp);
        bexp_t e;
        e.m = m; e.addr = a; e.wr = wr; e.wdata = wd; e.ws = ws; e.rdata = rd; e.resp = resp;
        bq.push_back(e);
    endtask

    task automatic drive_m(input int m, input logic sel, input logic [1:0] tr, input logic [15:0] a,
                           input logic wr, input logic rdy, input logic [31:0] wd);
        if (m == 0) begin
            HSEL_M0 = sel; HTRANS_M0 = tr; HADDR_M0 = a; HWRITE_M0 = wr; HREADY_M0 = rdy; HWDATA_M0 = wd;
        end else begin
            HSEL_M1 = sel; HTRANS_M1 = tr; HADDR_M1 = a; HWRITE_M1 = wr; HREADY_M1 = rdy; HWDATA_M1 = wd;
        end
    endtask

    // one AHB transfer from master m; returns after driving its data phase
    task automatic master_xfer(input int m, input logic [15:0] a, input logic wr, input logic [31:0] wd,
                               input logic [31:0] exp_rd, input logic exp_err, input int lat);
        int    n = 0;
        mexp_t e;
        @(posedge HCLK); #1;
        while (((m == 0) ? HREADYOUT_M0 : HREADYOUT_M1) !== 1'b1 && n < 300) begin
            @(posedge HCLK); #1;
            n++;
        end
        if (n >= 300) begin
            checks++; errors++;
            $display("FAIL m%0d_ready_timeout: got low expected high", m);
            return;
        end
        drive_m(m, 1'b1, 2'b10, a, wr, 1'b1, 32'h0);
        e.rdata = exp_rd; e.err = exp_err; e.lat = lat;
        if (m == 0) mq0.push_back(e); else mq1.push_back(e);
        @(posedge HCLK); #1;
        drive_m(m, 1'b0, 2'b00, 16'h0, 1'b0, 1'b1, wr ? wd : 32'h0);
    endtask

    // master-side scoreboard monitor
    logic [1:0] prev_rdy  = 2'b11;
    logic [1:0] prev_resp = 2'b00;
    logic [1:0] chk_clear = 2'b00;
    int         low_cnt [2] = '{0, 0};

    task automatic mon(input int m);
        logic        rdy, resp;
        logic [31:0] rd;
        mexp_t       e;
        rdy  = (m == 0) ? HREADYOUT_M0 : HREADYOUT_M1;
        resp = (m == 0) ? HRESP_M0 : HRESP_M1;
        rd   = (m == 0) ? HRDATA_M0 : HRDATA_M1;
        if (!HRESETn) begin
            if (m == 0) mq0.delete(); else mq1.delete();
            prev_rdy[m] = 1'b1; prev_resp[m] = 1'b0; chk_clear[m] = 1'b0; low_cnt[m] = 0;
            return;
        end
        if (chk_clear[m]) begin
            check($sformatf("m%0d_hresp_clear", m), 64'(resp), 64'(0));
            chk_clear[m] = 1'b0;
        end
        if (!rdy) begin
            low_cnt[m]++;
        end else if (!prev_rdy[m]) begin
            if (((m == 0) ? mq0.size() : mq1.size()) == 0) begin
                checks++; errors++;
                $display("FAIL m%0d_unexpected_completion: got completion expected none", m);
            end else begin
                e = (m == 0) ? mq0.pop_front() : mq1.pop_front();
                check($sformatf("m%0d_hrdata", m), 64'(rd), 64'(e.rdata));
                check($sformatf("m%0d_hresp", m), 64'(resp), 64'(e.err));
                if (e.err) begin
                    check($sformatf("m%0d_err_first_cycle", m), 64'(prev_resp[m]), 64'(1));
                    chk_clear[m] = 1'b1;
                end
                if (e.lat >= 0) check($sformatf("m%0d_latency", m), 64'(low_cnt[m]), 64'(e.lat));
            end
            low_cnt[m] = 0;
        end
        prev_rdy[m]  = rdy;
        prev_resp[m] = resp;
    endtask

    initial begin
        forever begin
            @(negedge HCLK);
            mon(0);
            mon(1);
        end
    end

    // bridge slave model: checks address/data phases and returns scripted responses
    bexp_t cur;
    int    br_cnt = 0;
    bit    br_ph = 1'b0;
    bit    addr_seen;

    task automatic drive_b();
        if (br_cnt == 0) begin
            B_HREADYOUT = 1'b1; B_HRDATA = cur.rdata; B_HRESP = cur.resp;
        end else begin
            B_HREADYOUT = 1'b0; B_HRDATA = 32'h0; B_HRESP = cur.resp && (br_cnt == 1);
        end
    endtask

    initial begin
        B_HREADYOUT = 1'b1; B_HRDATA = 32'h0; B_HRESP = 1'b0;
        forever begin
            @(negedge HCLK);
            addr_seen = 1'b0;
            if (HRESETn) begin
                if (B_HSEL && B_HTRANS == 2'b10) begin
                    if (bq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL bridge_unexpected_addr: got %h expected none", B_HADDR);
                    end else begin
                        addr_seen = 1'b1;
                        cur = bq.pop_front();
                        check("b_haddr", 64'(B_HADDR), 64'(cur.addr));
                        check("b_hwrite", 64'(B_HWRITE), 64'(cur.wr));
                        check("b_hsize", 64'(B_HSIZE), 64'(3'b010));
                        check("b_hprot", 64'(B_HPROT), 64'((cur.m == 1) ? 4'h5 : 4'h3));
                        check("b_hready_addr", 64'(B_HREADY), 64'(1));
                    end
                end else if (br_ph) begin
                    check("b_htrans_data", 64'(B_HTRANS), 64'(0));
                    check("b_hready_data", 64'(B_HREADY), 64'(B_HREADYOUT));
                    if (B_HREADYOUT && cur.wr) check("b_hwdata", 64'(B_HWDATA), 64'(cur.wdata));
                end
            end
            @(posedge HCLK); #1;
            if (!HRESETn) begin
                br_ph = 1'b0;
                B_HREADYOUT = 1'b1; B_HRDATA = 32'h0; B_HRESP = 1'b0;
            end else if (addr_seen) begin
                br_ph  = 1'b1;
                br_cnt = cur.ws;
                drive_b();
            end else if (br_ph) begin
                if (B_HREADYOUT) begin
                    br_ph = 1'b0;
                    B_HREADYOUT = 1'b1; B_HRDATA = 32'h0; B_HRESP = 1'b0;
                end else begin
                    br_cnt--;
                    drive_b();
                end
            end
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while (n < 300) begin
            @(negedge HCLK);
            if (!ARB_ACTIVE && !br_ph && bq.size() == 0 && mq0.size() == 0 && mq1.size() == 0) break;
            n++;
        end
        check(name, 64'(n < 300), 64'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hreadyout_m0"}, 64'(HREADYOUT_M0), 64'(1));
        check({tag, "_hreadyout_m1"}, 64'(HREADYOUT_M1), 64'(1));
        check({tag, "_hresp_m0"}, 64'(HRESP_M0), 64'(0));
        check({tag, "_hresp_m1"}, 64'(HRESP_M1), 64'(0));
        check({tag, "_hrdata_m0"}, 64'(HRDATA_M0), 64'(0));
        check({tag, "_hrdata_m1"}, 64'(HRDATA_M1), 64'(0));
        check({tag, "_b_hsel"}, 64'(B_HSEL), 64'(0));
        check({tag, "_b_htrans"}, 64'(B_HTRANS), 64'(0));
        check({tag, "_b_hready"}, 64'(B_HREADY), 64'(1));
        check({tag, "_b_haddr"}, 64'(B_HADDR), 64'(0));
        check({tag, "_b_hwdata"}, 64'(B_HWDATA), 64'(0));
        check({tag, "_arb_active"}, 64'(ARB_ACTIVE), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got still running expected finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int n;
        HRESETn = 1'b0;
        drive_m(0, 1'b0, 2'b00, 16'h0, 1'b0, 1'b1, 32'h0);
        drive_m(1, 1'b0, 2'b00, 16'h0, 1'b0, 1'b1, 32'h0);
        HSIZE_M0 = 3'b010; HSIZE_M1 = 3'b010;
        HPROT_M0 = 4'h3;   HPROT_M1 = 4'h5;
        #12;
        check_reset_outputs("por");
        @(posedge HCLK); @(posedge HCLK); #3;
        HRESETn = 1'b1;

        // requests that must be ignored
        for (int i = 0; i < 4; i++) begin
            @(posedge HCLK); #1;
            drive_m(0, ign_pat[i][3], ign_pat[i][2:1], 16'h0044, 1'b1, ign_pat[i][0], 32'h0);
            @(posedge HCLK); #1;
            drive_m(0, 1'b0, 2'b00, 16'h0, 1'b0, 1'b1, 32'h0);
            @(negedge HCLK);
            check($sformatf("ignored_%0d_hreadyout", i), 64'(HREADYOUT_M0), 64'(1));
            check($sformatf("ignored_%0d_active", i), 64'(ARB_ACTIVE), 64'(0));
        end

        // M0 zero-wait write
        push_b(0, 16'h0010, 1'b1, 32'hA5A5A5A5, 0, 32'h0, 1'b0);
        master_xfer(0, 16'h0010, 1'b1, 32'hA5A5A5A5, 32'h0, 1'b0, 4);
        wait_idle("idle_after_write");

        // M1 read with three bridge wait states
        push_b(1, 16'h0020, 1'b0, 32'h0, 3, 32'h12345678, 1'b0);
        master_xfer(1, 16'h0020, 1'b0, 32'h0, 32'h12345678, 1'b0, 7);
        wait_idle("idle_after_read");

        // simultaneous requests, twice each: grant order M0, M1, M0, M1
        push_b(0, 16'h0100, 1'b1, 32'h11111111, 0, 32'h0, 1'b0);
        push_b(1, 16'h0200, 1'b0, 32'h0, 0, 32'h22222222, 1'b0);
        push_b(0, 16'h0104, 1'b0, 32'h0, 0, 32'h33333333, 1'b0);
        push_b(1, 16'h0204, 1'b1, 32'h44444444, 0, 32'h0, 1'b0);
        fork
            begin
                master_xfer(0, 16'h0100, 1'b1, 32'h11111111, 32'h0, 1'b0, -1);
                master_xfer(0, 16'h0104, 1'b0, 32'h0, 32'h33333333, 1'b0, -1);
            end
            begin
                master_xfer(1, 16'h0200, 1'b0, 32'h0, 32'h22222222, 1'b0, -1);
                master_xfer(1, 16'h0204, 1'b1, 32'h44444444, 32'h0, 1'b0, -1);
            end
        join
        wait_idle("idle_after_round_robin");

        // bridge error on M0 while M1 waits
        push_b(0, 16'h0300, 1'b1, 32'hDEADBEEF, 1, 32'h0, 1'b1);
        push_b(1, 16'h0304, 1'b0, 32'h0, 0, 32'hCAFEF00D, 1'b0);
        fork
            master_xfer(0, 16'h0300, 1'b1, 32'hDEADBEEF, 32'h0, 1'b1, 6);
            master_xfer(1, 16'h0304, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0, 8);
        join
        wait_idle("idle_after_error");

        // reset during a long data phase
        push_b(0, 16'h0400, 1'b0, 32'h0, 8, 32'h55555555, 1'b0);
        master_xfer(0, 16'h0400, 1'b0, 32'h0, 32'h55555555, 1'b0, -1);
        n = 0;
        while (!br_ph && n < 100) begin
            @(negedge HCLK);
            n++;
        end
        check("reached_data_phase", 64'(br_ph), 64'(1));
        @(posedge HCLK); @(posedge HCLK); #2;
        HRESETn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge HCLK); #3;
        HRESETn = 1'b1;

        push_b(1, 16'h0500, 1'b0, 32'h0, 0, 32'h0BADBEEF, 1'b0);
        master_xfer(1, 16'h0500, 1'b0, 32'h0, 32'h0BADBEEF, 1'b0, 4);
        wait_idle("idle_after_reset_recovery");

        repeat (3) @(negedge HCLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
